// File: rtl/video_capture_in_if.sv
// Video capture bundle: raw composite-decoded inputs in, framebuffer-facing capture results out.
interface video_capture_in_if;
    logic [2:0] rgb_in;
    logic       hsync_n;
    logic       vsync_n;
    logic [2:0] rgb_111_out;
    logic       display_en;
    logic       frame_start_flag;
    logic       armed;

    modport master (
        output rgb_in,
        output hsync_n,
        output vsync_n,
        input  rgb_111_out,
        input  display_en,
        input  frame_start_flag,
        input  armed
    );

    modport slave (
        input  rgb_in,
        input  hsync_n,
        input  vsync_n,
        output rgb_111_out,
        output display_en,
        output frame_start_flag,
        output armed
    );
endinterface

// File: rtl/video_capture_in.sv
// Capture stage: synchronises async RGB111 video and sync strobes, counts pixels and lines, and
// presents slot-stable display_en / rgb / frame-start signals to the framebuffer write side.
module video_capture_in #(
    parameter int unsigned H_START  = 128,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_START  = 23,
    parameter int unsigned V_ACTIVE = 288,
    parameter int unsigned PIX_W    = 11,
    parameter int unsigned LINE_W   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        clkPhase,
    video_capture_in_if.slave vid
);

    // Window bounds carry one extra bit so the end compare never wraps.
    localparam logic [PIX_W:0]  HFirst = (PIX_W + 1)'(H_START);
    localparam logic [PIX_W:0]  HEnd   = (PIX_W + 1)'(H_START + H_ACTIVE);
    localparam logic [LINE_W:0] VFirst = (LINE_W + 1)'(V_START);
    localparam logic [LINE_W:0] VEnd   = (LINE_W + 1)'(V_START + V_ACTIVE);

    logic [2:0]        rgb_s1_q, rgb_s2_q;
    logic              h_s1_q, h_s2_q, h_s3_q;
    logic              v_s1_q, v_s2_q, v_s3_q;
    logic              h_fall, v_fall, slot_end;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              armed_q, frame_start_q;
    logic              in_window;
    logic              display_en_q, display_en_d;
    logic [2:0]        rgb_out_q, rgb_out_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_s1_q <= 3'b000;
            rgb_s2_q <= 3'b000;
            h_s1_q   <= 1'b1;
            h_s2_q   <= 1'b1;
            h_s3_q   <= 1'b1;
            v_s1_q   <= 1'b1;
            v_s2_q   <= 1'b1;
            v_s3_q   <= 1'b1;
        end else begin
            rgb_s1_q <= vid.rgb_in;
            rgb_s2_q <= rgb_s1_q;
            h_s1_q   <= vid.hsync_n;
            h_s2_q   <= h_s1_q;
            h_s3_q   <= h_s2_q;
            v_s1_q   <= vid.vsync_n;
            v_s2_q   <= v_s1_q;
            v_s3_q   <= v_s2_q;
        end
    end

    assign h_fall   = h_s3_q & ~h_s2_q;
    assign v_fall   = v_s3_q & ~v_s2_q;
    assign slot_end = (clkPhase == 3'd5);

    // A vsync edge beats a coincident hsync edge so a new field always starts on line 0.
    always_comb begin
        line_d = line_q;
        if (v_fall) begin
            line_d = '0;
        end else if (h_fall && (line_q != '1)) begin
            line_d = line_q + 1'b1;
        end

        pix_d = pix_q;
        if (h_fall) begin
            pix_d = '0;
        end else if (slot_end && (pix_q != '1)) begin
            pix_d = pix_q + 1'b1;
        end
    end

    always_comb begin
        in_window = armed_q
                    && ({1'b0, line_q} >= VFirst) && ({1'b0, line_q} < VEnd)
                    && ({1'b0, pix_q} >= HFirst) && ({1'b0, pix_q} < HEnd);
    end

    // Outputs only move on the last phase of a slot, holding for the whole next slot.
    always_comb begin
        display_en_d = display_en_q;
        rgb_out_d    = rgb_out_q;
        if (slot_end) begin
            display_en_d = in_window;
            rgb_out_d    = in_window ? rgb_s2_q : 3'b000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q         <= '0;
            line_q        <= '0;
            armed_q       <= 1'b0;
            frame_start_q <= 1'b0;
            display_en_q  <= 1'b0;
            rgb_out_q     <= 3'b000;
        end else begin
            pix_q         <= pix_d;
            line_q        <= line_d;
            armed_q       <= armed_q | v_fall;
            frame_start_q <= v_fall;
            display_en_q  <= display_en_d;
            rgb_out_q     <= rgb_out_d;
        end
    end

    assign vid.rgb_111_out      = rgb_out_q;
    assign vid.display_en       = display_en_q;
    assign vid.frame_start_flag = frame_start_q;
    assign vid.armed            = armed_q;

endmodule
